// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory sequencing controller.
// Holds the FSM state encoding, word-index slice bounds and the address fault check.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int MEM_WORDS = 1024;
    localparam int WIDX_HI   = 11;
    localparam int WIDX_LO   = 2;
    localparam int ALIGN_HI  = 1;
    localparam int RANGE_LO  = 12;

    // A byte address is usable only if it is word aligned and inside the 4 KiB window.
    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr[ALIGN_HI:0] != '0) || (addr[31:RANGE_LO] != '0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a combinational one-hot grant.
// The priority pointer moves to the loser only when both requesters contend.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (advance && (req == 2'b11)) begin
            r_ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises load/store requests from two requesters onto the single-port data memory,
// returning exactly one response pulse per accepted request.
//
// state | meaning
// IDLE  | arbitrate, capture winner; faulty address goes straight to RESP
// ISSUE | memory strobe on the bus for one cycle
// WAIT  | count out the memory read latency, then capture read data
// RESP  | one-cycle response pulse to the captured requester
module dmem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_isLd,
    input  logic              r0_isSt,
    input  logic [31:0]       r0_addr,
    input  logic [31:0]       r0_wdata,
    output logic              r0_resp_valid,
    output logic [31:0]       r0_resp_data,
    output logic              r0_resp_err,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_isLd,
    input  logic              r1_isSt,
    input  logic [31:0]       r1_addr,
    input  logic [31:0]       r1_wdata,
    output logic              r1_resp_valid,
    output logic [31:0]       r1_resp_data,
    output logic              r1_resp_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    state_t              r_state;
    logic                r_id;
    logic                r_is_ld;
    logic [2:0]          r_wait_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [1:0]          r_resp_valid;
    logic [31:0]         r_resp_data;
    logic                r_resp_err;

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_idle;
    logic                w_accept;
    logic                w_sel;
    logic                w_sel_ld;
    logic                w_sel_st;
    logic [31:0]         w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic                w_fault;

    assign w_req  = {r1_valid, r0_valid};
    assign w_idle = (r_state == IDLE) && !rst;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    assign w_accept    = w_idle && (w_gnt != 2'b00);
    assign w_sel       = w_gnt[1];
    assign w_sel_ld    = w_sel ? r1_isLd  : r0_isLd;
    assign w_sel_st    = w_sel ? r1_isSt  : r0_isSt;
    assign w_sel_addr  = w_sel ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_sel ? r1_wdata : r0_wdata;
    assign w_fault     = addr_fault(w_sel_addr);

    assign r0_ready = w_idle && w_gnt[0];
    assign r1_ready = w_idle && w_gnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_id         <= 1'b0;
            r_is_ld      <= 1'b0;
            r_wait_cnt   <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 2'b00;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_sel;
                        // Load-and-store together behaves as a store: no read is performed.
                        r_is_ld <= w_sel_ld && !w_sel_st;
                        if (w_fault) begin
                            r_resp_valid <= w_gnt;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= '0;
                            r_state      <= RESP;
                        end else begin
                            r_mem_en    <= w_sel_ld || w_sel_st;
                            r_mem_we    <= w_sel_st;
                            r_mem_addr  <= ADDR_W'(w_sel_addr[WIDX_HI:WIDX_LO]);
                            r_mem_wdata <= w_sel_wdata;
                            r_state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    if (r_is_ld) begin
                        r_wait_cnt <= LAT_INIT;
                        r_state    <= WAIT;
                    end else begin
                        r_resp_valid <= r_id ? 2'b10 : 2'b01;
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b0;
                        r_state      <= RESP;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_resp_data  <= mem_rdata;
                        r_resp_valid <= r_id ? 2'b10 : 2'b01;
                        r_resp_err   <= 1'b0;
                        r_state      <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    r_resp_valid <= 2'b00;
                    r_resp_data  <= '0;
                    r_resp_err   <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign r0_resp_valid = r_resp_valid[0];
    assign r1_resp_valid = r_resp_valid[1];
    assign r0_resp_data  = r_resp_valid[0] ? r_resp_data : '0;
    assign r1_resp_data  = r_resp_valid[1] ? r_resp_data : '0;
    assign r0_resp_err   = r_resp_valid[0] && r_resp_err;
    assign r1_resp_err   = r_resp_valid[1] && r_resp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural memory with fixed read latency,
// expected responses queued at handshake and compared when a response pulse appears.
module tb_dmem_arbiter;

    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst;
    logic        r0_valid, r0_ready, r0_isLd, r0_isSt;
    logic [31:0] r0_addr, r0_wdata, r0_resp_data;
    logic        r0_resp_valid, r0_resp_err;
    logic        r1_valid, r1_ready, r1_isLd, r1_isSt;
    logic [31:0] r1_addr, r1_wdata, r1_resp_data;
    logic        r1_resp_valid, r1_resp_err;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_isLd(r0_isLd), .r0_isSt(r0_isSt),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_resp_valid(r0_resp_valid),
        .r0_resp_data(r0_resp_data), .r0_resp_err(r0_resp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_isLd(r1_isLd), .r1_isSt(r1_isSt),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_resp_valid(r1_resp_valid),
        .r1_resp_data(r1_resp_data), .r1_resp_err(r1_resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] pipe_d  [RD_LAT];
    logic        pipe_v  [RD_LAT];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External memory: registered read pipeline, data valid RD_LAT cycles after the strobe.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        pipe_d[0] <= mem[mem_addr];
        pipe_v[0] <= mem_en && !mem_we;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end
    assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBAD0BAD0;

    function automatic void push_exp(input int id, input logic ld, input logic st,
                                     input logic [31:0] addr, input logic [31:0] wdata);
        exp_t x;
        x.id   = id;
        x.err  = 1'b0;
        x.data = 32'h0;
        if (addr[1:0] != 2'b00 || addr[31:12] != 20'h0) begin
            x.err = 1'b1;
            x.due = cyc + 1;
        end else if (st) begin
            ref_mem[addr[11:2]] = wdata;
            x.due = cyc + 2;
        end else if (ld) begin
            x.data = ref_mem[addr[11:2]];
            x.due  = cyc + 2 + RD_LAT;
        end else begin
            x.due = cyc + 2;
        end
        q.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (r0_resp_valid || r1_resp_valid) begin
                n_checks++;
                if (r0_resp_valid && r1_resp_valid) begin
                    n_fail++;
                    $display("FAIL both_resp cycle %0d: both resp_valid high", cyc);
                end
                if (q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_resp cycle %0d: r0=%0b r1=%0b, none expected",
                             cyc, r0_resp_valid, r1_resp_valid);
                end else begin
                    e = q.pop_front();
                    n_checks += 3;
                    if ((r1_resp_valid ? 1 : 0) !== e.id) begin
                        n_fail++;
                        $display("FAIL resp_id got r%0d, expected r%0d", r1_resp_valid ? 1 : 0, e.id);
                    end
                    if (cyc !== e.due) begin
                        n_fail++;
                        $display("FAIL resp_cycle got %0d, expected %0d", cyc, e.due);
                    end
                    if ((r1_resp_valid ? {r1_resp_data, r1_resp_err} : {r0_resp_data, r0_resp_err})
                        !== {e.data, e.err}) begin
                        n_fail++;
                        $display("FAIL resp_payload got data=%h err=%0b, expected data=%h err=%0b",
                                 r1_resp_valid ? r1_resp_data : r0_resp_data,
                                 r1_resp_valid ? r1_resp_err : r0_resp_err, e.data, e.err);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL resp_missing cycle %0d: no response for r%0d due at %0d", cyc, e.id, e.due);
            end
            if (r0_valid && r0_ready) push_exp(0, r0_isLd, r0_isSt, r0_addr, r0_wdata);
            if (r1_valid && r1_ready) push_exp(1, r1_isLd, r1_isSt, r1_addr, r1_wdata);
        end
    end

    task automatic drive(input int id, input logic v, input logic ld, input logic st,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            r0_valid = v; r0_isLd = ld; r0_isSt = st; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_valid = v; r1_isLd = ld; r1_isSt = st; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    // Returns just after the accepting edge, i.e. early in cycle T+1.
    task automatic send(input int id, input logic ld, input logic st,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bit ok = 0;
        @(posedge clk); #1;
        drive(id, 1'b1, ld, st, addr, wdata);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if ((id == 0 && r0_ready) || (id == 1 && r1_ready)) ok = 1;
        end
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout r%0d addr %h: ready never seen, expected within 50 cycles", id, addr);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        n_checks++;
        if ({r0_ready, r1_ready, r0_resp_valid, r1_resp_valid, r0_resp_data, r1_resp_data,
             r0_resp_err, r1_resp_err, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: r0_ready=%0b mem_en=%0b mem_addr=%h, expected all 0",
                     r0_ready, mem_en, mem_addr);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store();
        send(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd4, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL store_issue got en=%0b we=%0b addr=%0d wdata=%h, expected 1 1 4 deadbeef",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        drain();
    endtask

    task automatic test_load();
        send(1, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd4}) begin
            n_fail++;
            $display("FAIL load_issue got en=%0b we=%0b addr=%0d, expected 1 0 4", mem_en, mem_we, mem_addr);
        end
        drain();
        send(0, 1'b1, 1'b0, 32'h3FC, 32'h0);
        drain();
    endtask

    task automatic test_contention();
        int g[$];
        bit both_rdy = 0;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h11110000);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h22220000);
        for (int i = 0; i < 60 && g.size() < 4; i++) begin
            @(negedge clk);
            if (r0_ready && r1_ready) both_rdy = 1;
            if (r0_ready) g.push_back(0);
            else if (r1_ready) g.push_back(1);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (both_rdy) begin
            n_fail++;
            $display("FAIL contention_both_ready got both ready, expected one winner");
        end
        n_checks++;
        if (g.size() != 4) begin
            n_fail++;
            $display("FAIL contention_count got %0d grants, expected 4", g.size());
        end
        for (int i = 0; i < g.size(); i++) begin
            n_checks++;
            if (g[i] != i % 2) begin
                n_fail++;
                $display("FAIL contention_order grant %0d got r%0d, expected r%0d", i, g[i], i % 2);
            end
        end
        drain();
    endtask

    task automatic test_fault();
        logic [31:0] bad [2];
        bit seen_en;
        bad[0] = 32'h2;
        bad[1] = 32'h1000;
        for (int k = 0; k < 2; k++) begin
            seen_en = 0;
            send(0, 1'b1, 1'b0, bad[k], 32'h0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (mem_en) seen_en = 1;
            end
            n_checks++;
            if (seen_en) begin
                n_fail++;
                $display("FAIL fault_no_access addr %h: mem_en seen, expected none", bad[k]);
            end
            drain();
        end
    endtask

    task automatic test_noop();
        send(0, 1'b0, 1'b0, 32'h30, 32'h12345678);
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL noop_issue got mem_en=%0b, expected 0", mem_en);
        end
        drain();
    endtask

    task automatic test_ld_st();
        send(1, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd8, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL ldst_issue got en=%0b we=%0b addr=%0d wdata=%h, expected 1 1 8 cafef00d",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        drain();
        send(0, 1'b1, 1'b0, 32'h20, 32'h0);
        drain();
    endtask

    task automatic test_reset_mid();
        send(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        q.delete();
        #1;
        n_checks++;
        if ({r0_ready, r1_ready, r0_resp_valid, r1_resp_valid, r0_resp_data, r1_resp_data,
             r0_resp_err, r1_resp_err, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: resp=%0b%0b mem_en=%0b, expected all 0",
                     r0_resp_valid, r1_resp_valid, mem_en);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        n_checks++;
        if (r1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_regrant got r1_ready=%0b, expected 1", r1_ready);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hA5000000 ^ (i * 32'h00010101);
            ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010101);
        end
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_d[i] = 32'h0;
            pipe_v[i] = 1'b0;
        end
        test_reset();
        test_store();
        test_load();
        test_contention();
        test_fault();
        test_noop();
        test_ld_st();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
